// File: rtl/pipe_operand_feeder_if.sv
// Handshake and data bundle between the operand feeder, its upstream producer
// and the 3-stage arithmetic pipeline it drives.
interface pipe_operand_feeder_if #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int TAGW  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic [N-1:0]    in_c;
  logic [N-1:0]    in_d;
  logic            iss_en;
  logic [N-1:0]    iss_a;
  logic [N-1:0]    iss_b;
  logic [N-1:0]    iss_c;
  logic [N-1:0]    iss_d;
  logic            iss_valid;
  logic [N-1:0]    f_in;
  logic            res_valid;
  logic [N-1:0]    res_f;
  logic [TAGW-1:0] res_tag;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, iss_en, f_in,
    input  in_ready, iss_a, iss_b, iss_c, iss_d, iss_valid,
           res_valid, res_f, res_tag, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, iss_en, f_in,
    output in_ready, iss_a, iss_b, iss_c, iss_d, iss_valid,
           res_valid, res_f, res_tag, count
  );
endinterface

// File: rtl/pipe_operand_feeder.sv
// Issue stage for the 3-stage arithmetic pipeline: buffers operand sets in a
// small FIFO, issues one per cycle and tags the returning F with valid/sequence.
module pipe_operand_feeder #(
  parameter int N     = 10,
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  parameter int TAGW  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_operand_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
  } opset_t;

  opset_t            mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;
  logic              in_ready;

  opset_t            iss_q;
  logic              iss_valid_q;
  logic [TAGW-1:0]   iss_tag_q;
  logic [TAGW-1:0]   tag_ctr;

  logic [LAT-1:0]            vld_sr;
  logic [LAT-1:0][TAGW-1:0]  tag_sr;

  // Full-ness is judged on the registered count only; a same-cycle pop does
  // not open a slot until the next cycle.
  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign pop      = bus.iss_en && (cnt != '0);

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_c, bus.in_d};
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values of their neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      tag_ctr     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      iss_valid_q <= pop;
      if (pop) begin
        iss_q     <= mem[rd_ptr];
        iss_tag_q <= tag_ctr;
        tag_ctr   <= tag_ctr + TAGW'(1);
      end
    end
  end

  // Valid/tag travel alongside the data inside the arithmetic pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      tag_sr <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
      vld_sr[0] <= iss_valid_q;
      tag_sr[0] <= iss_tag_q;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.count     = cnt;
  assign bus.iss_a     = iss_q.a;
  assign bus.iss_b     = iss_q.b;
  assign bus.iss_c     = iss_q.c;
  assign bus.iss_d     = iss_q.d;
  assign bus.iss_valid = iss_valid_q;
  assign bus.res_valid = vld_sr[LAT-1];
  assign bus.res_tag   = tag_sr[LAT-1];
  assign bus.res_f     = vld_sr[LAT-1] ? bus.f_in : '0;
endmodule

// File: tb/tb_pipe_operand_feeder.sv
// Self-checking bench: models the arithmetic pipeline and scoreboards every
// returned result against the sets accepted upstream.
module tb_pipe_operand_feeder;
  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int TAGW  = 8;

  typedef struct {
    logic [N-1:0]    f;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic clk;
  logic rst_n;

  pipe_operand_feeder_if #(.N(N), .DEPTH(DEPTH), .TAGW(TAGW)) bus ();

  pipe_operand_feeder #(.N(N), .DEPTH(DEPTH), .LAT(LAT), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Arithmetic pipeline model: capture, add/sub, multiply (not reset).
  logic [N-1:0] p_ab, p_cd, p_d1, p_sum, p_d2, p_f;
  always @(posedge clk) begin
    p_ab  <= N'(bus.iss_a + bus.iss_b);
    p_cd  <= N'(bus.iss_c - bus.iss_d);
    p_d1  <= bus.iss_d;
    p_sum <= N'(p_ab + p_cd);
    p_d2  <= p_d1;
    p_f   <= N'(p_sum * p_d2);
  end
  assign bus.f_in = p_f;

  int n_cmp = 0;
  int n_err = 0;
  exp_t exp_q[$];
  logic [TAGW-1:0] exp_tag = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_f(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] s;
    s = N'(a + b);
    s = N'(s + N'(c - d));
    return N'(s * d);
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_set(input logic [N-1:0] a, b, c, d);
    int w;
    exp_t e;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready) begin
      if (w++ > 200) begin
        check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    e.f   = model_f(a, b, c, d);
    e.tag = exp_tag;
    exp_q.push_back(e);
    exp_tag = exp_tag + TAGW'(1);
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Result monitor: pop and compare on every valid result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_f", bus.res_f, e.f);
          check("res_tag", bus.res_tag, e.tag);
        end
      end else begin
        check("res_f_idle", bus.res_f, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] iss_pat;
    logic [7:0] res_pat;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0;
    bus.iss_en = 1'b1;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_iss_valid", bus.iss_valid, 0);
    check("rst_iss_a", bus.iss_a, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_tag", bus.res_tag, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 1);

    // Single set and its latency.
    push_set(10, 12, 6, 3);
    bus.in_valid = 1'b0;
    check("single_iss_early", bus.iss_valid, 0);
    check("single_count", bus.count, 1);
    @(negedge clk);
    check("single_iss_valid", bus.iss_valid, 1);
    check("single_iss_a", bus.iss_a, 10);
    check("single_iss_d", bus.iss_d, 3);
    @(negedge clk);
    check("single_res_early1", bus.res_valid, 0);
    @(negedge clk);
    check("single_res_early2", bus.res_valid, 0);
    @(negedge clk);
    check("single_res_valid", bus.res_valid, 1);
    drain();

    // Back-to-back pair.
    push_set(10, 10, 5, 3);
    push_set(20, 1, 1, 4);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_res0", bus.res_valid, 1);
    @(negedge clk);
    check("b2b_res1", bus.res_valid, 1);
    @(negedge clk);
    check("b2b_res_end", bus.res_valid, 0);
    drain();

    // Fill with issue paused, fifth set held until a pop frees a slot.
    bus.iss_en = 1'b0;
    for (int i = 0; i < 4; i++) push_set(N'(i + 1), N'(2 * i), N'(7), N'(i));
    fork
      push_set(100, 200, 300, 9);
      begin
        check("full_count", bus.count, 4);
        check("full_ready", bus.in_ready, 0);
        @(negedge clk);
        check("full_hold_count", bus.count, 4);
        bus.iss_en = 1'b1;
        @(negedge clk);
        check("full_pop_count", bus.count, 3);
        check("full_pop_ready", bus.in_ready, 1);
      end
    join
    bus.in_valid = 1'b0;
    check("full_after_count", bus.count, 3);
    drain();

    // Continuous stream across the tag wrap.
    fork
      begin
        for (int i = 0; i < 257; i++)
          push_set(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)),
                   N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
        bus.in_valid = 1'b0;
      end
      begin
        for (int w = 0; !bus.res_valid && w < 20; w++) @(negedge clk);
        check("stream_start", bus.res_valid, 1);
        repeat (256) begin
          @(negedge clk);
          check("stream_gap", bus.res_valid, 1);
        end
      end
    join
    drain();

    // Reset with sets in flight and queued.
    bus.iss_en = 1'b1;
    push_set(1, 2, 3, 4);
    push_set(5, 6, 7, 8);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.iss_en = 1'b0;
    push_set(11, 12, 13, 14);
    push_set(15, 16, 17, 18);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_tag = '0;
    #1;
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_iss_valid", bus.iss_valid, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_f", bus.res_f, 0);
    check("mid_rst_res_tag", bus.res_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.iss_en = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_res_valid", bus.res_valid, 0);
      check("post_rst_iss_valid", bus.iss_valid, 0);
    end
    push_set(10, 12, 6, 3);
    bus.in_valid = 1'b0;
    drain();

    // Issue-enable bubble with a full FIFO.
    bus.iss_en = 1'b0;
    for (int i = 0; i < 4; i++) push_set(N'(50 + i), N'(3 * i), N'(i), N'(i + 2));
    bus.in_valid = 1'b0;
    iss_pat = 8'b0001_1101;
    res_pat = 8'b1110_1000;
    bus.iss_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("bubble_iss_valid", bus.iss_valid, iss_pat[i]);
      check("bubble_res_valid", bus.res_valid, res_pat[i]);
      if (i == 0) bus.iss_en = 1'b0;
      if (i == 1) bus.iss_en = 1'b1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_operand_feeder.md
Name: pipe_operand_feeder

Overview:
Upstream issue stage for the team's 3-stage arithmetic pipeline, which computes F = ((A+B)+(C-D))*D mod 2^N and has no stall or valid of its own.
- Accepts operand sets {A,B,C,D} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues at most one set per cycle from registered outputs.
- Tracks each issued set through the pipeline latency so the returned F is presented with a valid flag and sequence tag.

Parameters:
N, 10, operand/result width (matches the arithmetic pipeline)
DEPTH, 4, FIFO entries; power of 2, >=2
LAT, 3, register stages in the arithmetic pipeline (iss_* capture to F update)
TAGW, 8, sequence tag width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operand set valid
in_ready  output  1  feeder can accept (count < DEPTH)
in_a, in_b, in_c, in_d  input  N each  operand set
iss_en  input  1  issue enable; 0 pauses issue, FIFO still fills
iss_a, iss_b, iss_c, iss_d  output  N each  registered operands to the pipeline A/B/C/D
iss_valid  output  1  iss_* hold a newly issued set this cycle
f_in  input  N  F output of the arithmetic pipeline
res_valid  output  1  f_in corresponds to an issued set
res_f  output  N  f_in when res_valid, else 0
res_tag  output  TAGW  sequence number of the set in res_f
count  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO pointers and count are 0. iss_* = 0 and iss_valid = 0. The valid/tag tracking chain is cleared. The issue tag counter is 0. res_valid = 0, res_f = 0, res_tag = 0. in_ready = 1 once released.
- Reset mid-operation: all queued and in-flight sets are discarded. The arithmetic pipeline's internal data is not reset but is ignored because the valid chain is cleared. Release is synchronous to the next clk edge.
- Push: when in_valid && in_ready at the clk edge, write {in_a..in_d} at wr_ptr. wr_ptr wraps modulo DEPTH.
- in_ready is combinational from count: in_ready = (count < DEPTH). in_ready does not depend on a same-cycle pop; there is no full-bypass.
- Pop/issue: when iss_en && count > 0 at the edge:
  - The FIFO head is registered into iss_*.
  - iss_valid <= 1; rd_ptr wraps modulo DEPTH.
  - The tag counter increments and wraps modulo 2^TAGW.
  - Otherwise iss_valid <= 0 and iss_* hold their last value.
- Empty FIFO: no bypass. A set pushed at edge k is earliest issued at edge k+1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full FIFO: in_ready = 0 and in_valid is ignored; a pop in the same cycle raises in_ready next cycle.
- Tracking chain: LAT-stage shift register of {iss_valid, issued tag}, shifting every clk. res_valid/res_tag are driven from the last stage.
- Latency, push at edge k, issue at edge k+1:
  - The pipeline captures iss_* at edge k+2 and F updates at edge k+1+LAT.
  - res_valid is high during the cycle after edge k+1+LAT (default k+4).
  - Back-to-back issue gives res_valid high on consecutive cycles.
- res_f is combinational: res_valid ? f_in : 0. The bench samples at the falling edge because the pipeline has intra-cycle assignment delays up to 6 time units with clock period 20.
- Arithmetic is owned by the pipeline and wraps mod 2^N. The feeder does not modify operands.

Test Plan:
- Single set A=10,B=12,C=6,D=3 pushed at edge k, iss_en=1 -> iss_valid high after edge k+1; res_valid=1, res_f=75, res_tag=0 after edge k+4.
- Back-to-back sets (10,10,5,3) and (20,1,1,4) on consecutive cycles -> res_valid high two consecutive cycles; res_f=66 then 72 (21-3=18, 18*4=72); tags 0,1.
- iss_en=0, push 5 sets -> count=4, in_ready=0 on the 5th set, which is held. Then iss_en=1 -> 5th accepted the cycle after the first pop; all 5 results return in order.
- 257 sets streamed -> tag wraps 255->0; no gaps in res_valid when input is continuous.
- rst_n asserted while 2 sets are queued and 2 in flight -> outputs 0 immediately; after release no res_valid until a new push; the first new result has tag 0.
- iss_en toggled 1,0,1 with full FIFO -> one-cycle bubble in iss_valid and res_valid; results unchanged and in order.
